// File: rtl/spi_master_ram_host_if.sv
// Local command/response bus and SPI pins of the host-side SPI initiator.
// The master modport is the initiator's view. The slave modport is the requester/link view.
interface spi_master_ram_host_if #(
   parameter int CMD_WIDTH = 10,
   parameter int WORD_SIZE = 8
);
   // Handshake rules:
   // - A command transfers on every clk edge where cmd_valid and cmd_ready are both high.
   // - While cmd_ready is low, cmd_valid and cmd_data may change freely.
   // - rsp_valid is a single-cycle pulse and has no back-pressure.
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [CMD_WIDTH-1:0] cmd_data;
   logic                 rsp_valid;
   logic [WORD_SIZE-1:0] rsp_data;
   logic                 busy;
   logic                 sclk;
   logic                 ss_n;
   logic                 mosi;
   logic                 miso;

   modport master (
      input  cmd_valid, cmd_data, miso,
      output cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
   );

   modport slave (
      output cmd_valid, cmd_data, miso,
      input  cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
   );
endinterface

// File: rtl/spi_master_ram_host.sv
// Host-side SPI mode-0 initiator: serialises 10-bit commands MSB-first.
// On read-data frames it also shifts back one word from MISO.
module spi_master_ram_host #(
   parameter int CLK_DIV   = 2,
   parameter int RD_GAP    = 2,
   parameter int SS_GAP    = 2,
   parameter int CMD_WIDTH = 10,
   parameter int WORD_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_master_ram_host_if.master  bus,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {IDLE, SETUP, TX, TURN, RX, GAP} state_t;

   // SS_GAP counts every ss_n-high cycle between frames, including the IDLE accept
   // cycle. GAP itself always lasts at least one cycle so the response pulse has a home.
   localparam int GAP_CYC = (SS_GAP > 2) ? SS_GAP - 1 : 1;

   state_t               state_q, state_d;
   logic [7:0]           div_q, div_d;
   logic [4:0]           bit_q, bit_d;
   logic [7:0]           gap_q, gap_d;
   logic [CMD_WIDTH-1:0] shift_q, shift_d;
   logic                 rd_q, rd_d;
   logic [WORD_SIZE-1:0] rx_q, rx_d;
   logic                 sclk_q, sclk_d;
   logic                 ss_n_q, ss_n_d;
   logic                 mosi_q, mosi_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;

   logic run;
   logic wrap;
   logic low_end;

   assign run     = (state_q == SETUP) || (state_q == TX) || (state_q == TURN) || (state_q == RX);
   assign wrap    = run && (div_q == 8'(CLK_DIV - 1));
   // The end of a low half is where every frame-phase decision is taken.
   assign low_end = wrap && !sclk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         gap_q       <= '0;
         shift_q     <= '0;
         rd_q        <= 1'b0;
         rx_q        <= '0;
         sclk_q      <= 1'b0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         gap_q       <= gap_d;
         shift_q     <= shift_d;
         rd_q        <= rd_d;
         rx_q        <= rx_d;
         sclk_q      <= sclk_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.cmd_valid) state_d = SETUP;
         SETUP:   if (wrap) state_d = TX;
         TX: begin
            if (low_end && bit_q == 5'(CMD_WIDTH)) begin
               if (!rd_q)           state_d = GAP;
               else if (RD_GAP == 0) state_d = RX;
               else                 state_d = TURN;
            end
         end
         TURN:    if (low_end && bit_q == 5'(RD_GAP)) state_d = RX;
         RX:      if (low_end && bit_q == 5'(WORD_SIZE)) state_d = GAP;
         GAP:     if (gap_q == 8'(GAP_CYC - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_d       = run ? (wrap ? 8'd0 : div_q + 8'd1) : 8'd0;
      bit_d       = bit_q;
      gap_d       = gap_q;
      shift_d     = shift_q;
      rd_d        = rd_q;
      rx_d        = rx_q;
      sclk_d      = sclk_q;
      ss_n_d      = ss_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;

      if (state_q == IDLE && bus.cmd_valid) begin
         shift_d = bus.cmd_data;
         rd_d    = (bus.cmd_data[CMD_WIDTH-1 -: 2] == 2'b11);
         ss_n_d  = 1'b0;
         mosi_d  = bus.cmd_data[CMD_WIDTH-1];
         bit_d   = '0;
      end else if (wrap && sclk_q) begin
         // Falling edge: mosi moves only here; zero fill leaves mosi low after the last bit.
         sclk_d = 1'b0;
         bit_d  = bit_q + 5'd1;
         if (state_q == TX) begin
            shift_d = {shift_q[CMD_WIDTH-2:0], 1'b0};
            mosi_d  = shift_q[CMD_WIDTH-2];
         end
      end else if (low_end && state_d == GAP) begin
         ss_n_d      = 1'b1;
         mosi_d      = 1'b0;
         gap_d       = '0;
         rsp_valid_d = rd_q;
         if (rd_q) rsp_data_d = rx_q;
      end else if (low_end) begin
         sclk_d = 1'b1;
         if (state_d != state_q) bit_d = '0;
         if (state_d == RX) rx_d = {rx_q[WORD_SIZE-2:0], bus.miso};
      end else if (state_q == GAP) begin
         gap_d = gap_q + 8'd1;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE) && !rst;
   assign bus.busy      = (state_q != IDLE);
   assign bus.sclk      = sclk_q;
   assign bus.ss_n      = ss_n_q;
   assign bus.mosi      = mosi_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign dbg_state     = state_q;

endmodule
